cronometro_min_counter: RTL

Minutes stage of the stopwatch: two BCD digit counters (units 0-9, tens 0-5) advanced by the one-cycle carry pulse from the seconds stage. It produces the minute digits and a carry pulse to the hours stage. It also owns the start/stop/lap/clear control FSM, whose run enable is shared with the seconds stage, and a lap-freeze display latch. The tens-digit value it produces is what the tens-of-minutes flip-flop set/reset excitation logic downstream decodes.

---
 rtl/cronometro_pkg.sv | 21 ++
 rtl/bcd_digit_counter.sv | 40 ++++
 rtl/cronometro_min_counter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch stages (seconds, minutes, hours).
// Holds the control FSM state type, the BCD digit width and the default
// digit terminal values reused by every counting stage.
package cronometro_pkg;

  // Width of one BCD digit.
  localparam int unsigned BcdWidth = 4;

  // Default terminal values: units digit 0-9, tens digit 0-5.
  localparam int unsigned UniMaxDefault = 9;
  localparam int unsigned DezMaxDefault = 5;

  // Start/stop/lap/clear control FSM.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2,
    StLap     = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter with synchronous clear and count enable.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset (Q -> 0)
//   CLR  - synchronous clear, wins over EN
//   EN   - advance by one on this edge
//   Q    - current digit value
//   TC   - terminal count, combinational (Q == MAX) & EN; chains to next digit
module bcd_digit_counter
  import cronometro_pkg::*;
#(
  parameter int unsigned MAX = UniMaxDefault
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLR,
  input  logic                EN,
  output logic [BcdWidth-1:0] Q,
  output logic                TC
);

  localparam logic [BcdWidth-1:0] MaxQ = BcdWidth'(MAX);

  logic [BcdWidth-1:0] q_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= '0;
    end else if (CLR) begin
      q_q <= '0;
    end else if (EN) begin
      // >= also folds any out-of-range value back to zero.
      q_q <= (q_q >= MaxQ) ? '0 : q_q + BcdWidth'(1);
    end
  end

  assign Q  = q_q;
  assign TC = (q_q == MaxQ) & EN;

endmodule

// File: rtl/cronometro_min_counter.sv
// Minutes stage of the stopwatch.
// Counts minutes 00-59 in two BCD digits on each SEC_CARRY pulse while the
// control FSM is RUNNING or LAP, and emits HOUR_CARRY on the 59->00 rollover.
// Also owns the start/stop/lap/clear FSM and the lap-freeze display latch.
// Ports:
//   CLK, RST    - clock and asynchronous active-high reset
//   SEC_CARRY   - one-cycle pulse from seconds stage on 59->00
//   START_STOP  - toggle run/pause pulse
//   LAP         - freeze/unfreeze display pulse
//   CLEAR       - zero everything and return to idle
//   RUN         - count enable for the seconds stage (RUNNING or LAP)
//   MIN_UNI     - displayed units-of-minutes digit
//   MIN_DEZ     - displayed tens-of-minutes digit
//   HOUR_CARRY  - one-cycle pulse on minute rollover
//   FROZEN      - display held (LAP state)
module cronometro_min_counter
  import cronometro_pkg::*;
#(
  parameter int unsigned UNI_MAX = UniMaxDefault,
  parameter int unsigned DEZ_MAX = DezMaxDefault
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SEC_CARRY,
  input  logic                START_STOP,
  input  logic                LAP,
  input  logic                CLEAR,
  output logic                RUN,
  output logic [BcdWidth-1:0] MIN_UNI,
  output logic [BcdWidth-1:0] MIN_DEZ,
  output logic                HOUR_CARRY,
  output logic                FROZEN
);

  state_e              state_q, state_d;
  logic                run_q;
  logic                frozen_q;
  logic                hour_carry_q;
  logic [BcdWidth-1:0] hold_uni_q;
  logic [BcdWidth-1:0] hold_dez_q;

  logic [BcdWidth-1:0] cnt_uni;
  logic [BcdWidth-1:0] cnt_dez;
  logic                uni_tc;
  logic                dez_tc;
  logic                cnt_en;

  // run_q mirrors the pre-edge state, so a carry arriving with the pause
  // pulse is still counted; CLEAR suppresses the increment outright.
  assign cnt_en = run_q & SEC_CARRY & ~CLEAR;

  bcd_digit_counter #(
    .MAX(UNI_MAX)
  ) u_uni (
    .CLK(CLK),
    .RST(RST),
    .CLR(CLEAR),
    .EN (cnt_en),
    .Q  (cnt_uni),
    .TC (uni_tc)
  );

  bcd_digit_counter #(
    .MAX(DEZ_MAX)
  ) u_dez (
    .CLK(CLK),
    .RST(RST),
    .CLR(CLEAR),
    .EN (uni_tc),
    .Q  (cnt_dez),
    .TC (dez_tc)
  );

  // Next state; CLEAR > START_STOP > LAP, lower-priority pulses dropped.
  always_comb begin
    state_d = state_q;
    if (CLEAR) begin
      state_d = StIdle;
    end else if (START_STOP) begin
      case (state_q)
        StIdle:    state_d = StRunning;
        StRunning: state_d = StPaused;
        StPaused:  state_d = StRunning;
        StLap:     state_d = StPaused;
        default:   state_d = StIdle;
      endcase
    end else if (LAP) begin
      case (state_q)
        StRunning: state_d = StLap;
        StLap:     state_d = StRunning;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      run_q        <= 1'b0;
      frozen_q     <= 1'b0;
      hour_carry_q <= 1'b0;
      hold_uni_q   <= '0;
      hold_dez_q   <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= (state_d == StRunning) || (state_d == StLap);
      frozen_q     <= (state_d == StLap);
      hour_carry_q <= dez_tc;
      // Track the shown value until frozen; on LAP entry this keeps the
      // value that was on the display when LAP was pressed.
      if (!frozen_q) begin
        hold_uni_q <= cnt_uni;
        hold_dez_q <= cnt_dez;
      end
    end
  end

  // Register-to-output select only; leaving LAP resyncs to the live count.
  assign MIN_UNI    = frozen_q ? hold_uni_q : cnt_uni;
  assign MIN_DEZ    = frozen_q ? hold_dez_q : cnt_dez;
  assign RUN        = run_q;
  assign FROZEN     = frozen_q;
  assign HOUR_CARRY = hour_carry_q;

endmodule
